// File: rtl/inorm.sv
// ============================================================================
// Module   : inorm
// Purpose  : Iterative normalizer. Shifts an operand left until it is
//            normalized and reports the shift count. Provides count leading
//            zeros (unsigned mode) or count redundant sign bits (signed
//            mode) for the Forth core's normalize words. It uses the same
//            go/busy handshake as the iterative shifter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk   in   1      clock, rising edge
//   arstn in   1      asynchronous reset, active low
//   busy  out  1      operation in progress; go is ignored while high
//   go    in   1      start request, sampled on rising clk
//   sgn   in   1      0 = unsigned (leading zeros), 1 = signed (sign bits)
//   a     in   WIDTH  operand
//   y     out  WIDTH  normalized result (a << cnt)
//   cnt   out  7      left-shift count applied, 0..WIDTH
//   zero  out  1      operand was all-zero
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  datapath width, 32..64 (default 32)
// ----------------------------------------------------------------------------
// Build option
//   INORM_CHUNK_EN  When defined, the block takes 6-bit steps while that is
//                   safe, then 1-bit steps. When undefined, it takes only
//                   1-bit steps. Results are identical in both builds; only
//                   latency differs.
// ============================================================================
`default_nettype none

module inorm #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arstn,
    output logic             busy,
    input  logic             go,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic [6:0]       cnt,
    output logic             zero
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Count reported for an all-zero operand. A signed zero has WIDTH-1
    // redundant sign bits; an unsigned zero has WIDTH leading zeros.
    localparam logic [6:0] C_ZERO_CNT_U = 7'(WIDTH);
    localparam logic [6:0] C_ZERO_CNT_S = 7'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic             r_mode;     // latched sgn for the running operation
    logic [WIDTH-1:0] r_y;
    logic [6:0]       r_cnt;
    logic             r_zero;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [0:0]       w_state_next;
    logic             w_mode_next;
    logic [WIDTH-1:0] w_y_next;
    logic [6:0]       w_cnt_next;
    logic             w_zero_next;

    logic             w_a_zero;
    logic             w_single_ok;
    logic             w_chunk_ok;
    logic             w_step_ok;

    assign w_a_zero = (a == '0);

    // A 1-bit shift is safe while the top bit is not yet significant. In
    // unsigned mode this means the MSB is zero. In signed mode it means the
    // MSB duplicates the bit below it.
    assign w_single_ok = r_mode ? (r_y[WIDTH-1] == r_y[WIDTH-2])
                                : ~r_y[WIDTH-1];

`ifdef INORM_CHUNK_EN
    // A 6-bit shift is safe only when all six bits it discards are
    // redundant. In signed mode the bit that becomes the new MSB must also
    // match them; that is why seven bits are compared. With this rule a
    // chunk never shifts past the normalized position.
    assign w_chunk_ok = r_mode ? (r_y[WIDTH-1:WIDTH-7] == {7{r_y[WIDTH-1]}})
                               : (r_y[WIDTH-1:WIDTH-6] == 6'b000000);
`else
    assign w_chunk_ok = 1'b0;
`endif

    assign w_step_ok = w_chunk_ok | w_single_ok;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                // A zero operand is resolved in place, so busy never rises.
                if (go && !w_a_zero) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!w_step_ok) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy = (r_state == RUN);
    end

    // ------------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_mode_next = r_mode;
        w_y_next    = r_y;
        w_cnt_next  = r_cnt;
        w_zero_next = r_zero;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_mode_next = sgn;
                    if (w_a_zero) begin
                        w_y_next    = '0;
                        w_zero_next = 1'b1;
                        w_cnt_next  = sgn ? C_ZERO_CNT_S : C_ZERO_CNT_U;
                    end else begin
                        w_y_next    = a;
                        w_zero_next = 1'b0;
                        w_cnt_next  = 7'd0;
                    end
                end
            end
            RUN: begin
`ifdef INORM_CHUNK_EN
                if (w_chunk_ok) begin
                    w_y_next   = {r_y[WIDTH-7:0], 6'b000000};
                    w_cnt_next = r_cnt + 7'd6;
                end else if (w_single_ok) begin
                    w_y_next   = {r_y[WIDTH-2:0], 1'b0};
                    w_cnt_next = r_cnt + 7'd1;
                end
`else
                if (w_single_ok) begin
                    w_y_next   = {r_y[WIDTH-2:0], 1'b0};
                    w_cnt_next = r_cnt + 7'd1;
                end
`endif
                // When no step is allowed, y and cnt hold their final values.
            end
            default: begin
                w_y_next = r_y;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_mode <= 1'b0;
            r_y    <= '0;
            r_cnt  <= 7'd0;
            r_zero <= 1'b0;
        end else begin
            r_mode <= w_mode_next;
            r_y    <= w_y_next;
            r_cnt  <= w_cnt_next;
            r_zero <= w_zero_next;
        end
    end

    assign y    = r_y;
    assign cnt  = r_cnt;
    assign zero = r_zero;

endmodule

`default_nettype wire

// File: doc/inorm.md
Name: inorm

Overview:
- Iterative normalizer: the inverse of the iterative shifter. The shifter takes a value and a count and produces a shifted value; this block takes a value and produces the normalized value plus the left-shift count that normalized it.
- Serves the Forth core's normalize / count-leading-zeros / count-leading-sign-bits words.
- Same go/busy handshake as the shifter.
- Steps in 6-bit chunks while safe, then 1-bit steps to finish, trading latency against mux area.

Parameters:
WIDTH, 32, datapath width; legal range 32 to 64.

Ports:
clk  input  1  clock, rising edge
arstn  input  1  reset, asynchronous, active-low
busy  output  1  1 = operation in progress, go ignored
go  input  1  start request, sampled on rising clk
sgn  input  1  0 = unsigned (count leading zeros), 1 = signed (count redundant sign bits)
a  input  WIDTH  operand
y  output  WIDTH  normalized result, i.e. a shifted left by cnt
cnt  output  7  left-shift count applied, 0..WIDTH
zero  output  1  1 = operand was all-zero

Behaviour:
- Reset (async, arstn low): busy=0, y=0, cnt=0, zero=0, latched mode=0.
- Reset mid-operation aborts it immediately; no residue after release.
- States: IDLE (busy=0), RUN (busy=1).

IDLE:
- go is accepted only in IDLE. Edge with go=1:
  - mode <= sgn (latched; sgn is ignored afterwards).
  - If a==0: y<=0, zero<=1, cnt<=WIDTH (unsigned) or WIDTH-1 (signed). Stay IDLE; busy never rises; results valid the cycle after go.
  - Else: y<=a, cnt<=0, zero<=0, busy<=1, enter RUN.
- go=0 in IDLE: outputs hold.

RUN, one action per edge, evaluated on the current y, in priority order:
- 1. Chunk step, allowed if:
  - unsigned: y[WIDTH-1:WIDTH-6] all zero;
  - signed: y[WIDTH-1:WIDTH-7] all equal.
  - Action: y<=y<<6 with zero fill, cnt<=cnt+6.
- 2. Single step, allowed if:
  - unsigned: y[WIDTH-1]==0;
  - signed: y[WIDTH-1]==y[WIDTH-2].
  - Action: y<=y<<1 with zero fill, cnt<=cnt+1.
- 3. Otherwise normalized: busy<=0, return to IDLE. y and cnt hold.

RUN guarantees:
- The chunk conditions never overshoot normalization.
- Termination is guaranteed because a!=0 (signed -1 terminates at y=MSB-only, cnt=WIDTH-1).
- cnt never exceeds WIDTH-1 in RUN; 7-bit arithmetic, no wrap.

Latency and validity:
- busy is high for (steps+1) cycles.
- Results are valid and stable from the first cycle busy is low after go, until the next accepted go.
- y/cnt change during RUN; consumers must not sample them while busy=1.

Boundary conditions:
- go while busy=1, including the finishing cycle: ignored, not queued.
- go asserted continuously: a new operation is accepted on the first edge with busy=0.
- Already-normalized operand: 0 steps, busy high exactly 1 cycle, cnt=0.

Optional Feature:
INORM_CHUNK_EN
- Defined: 6-bit chunk steps enabled as above.
- Undefined: chunk rule removed; only 1-bit steps, so busy is high for cnt+1 cycles. Saves the 6-bit shift mux and the 7-bit compare.
- Results (y, cnt, zero) are identical in both builds; only timing differs.

Test Plan:
- WIDTH=32, sgn=0, a=0x00000001, pulse go -> busy high 7 cycles (5 chunks + 1 single + finish); then y=0x80000000, cnt=31, zero=0.
- sgn=0, a=0x00000000 -> busy stays 0; next cycle y=0, cnt=32, zero=1. Same with sgn=1 -> cnt=31, zero=1.
- sgn=1, a=0xFFFFFFFF -> y=0x80000000, cnt=31, busy 7 cycles. sgn=1, a=0x00000003 -> y=0x60000000, cnt=29, busy 10 cycles (4 chunks + 5 singles + finish).
- sgn=0, a=0x80000000 -> busy high 1 cycle, y=0x80000000, cnt=0.
- Start a=0x00000001, then:
  - pulse go with a=0x00F00000 at cycle 3 -> ignored; result still cnt=31.
  - Drop arstn mid-run -> busy=0, y=0, cnt=0 immediately.
  - After release, a=0x00F00000, sgn=0 -> cnt=8, y=0xF0000000.
- INORM_CHUNK_EN undefined, sgn=0, a=0x00000001 -> busy high 32 cycles, y=0x80000000, cnt=31.
